field_scan_gen: RTL and testbench

//   Generalised successor to the single-cell field loader. After a start pulse it walks a FIELD_W x FIELD_H

---
 rtl/field_scan_gen_pkg.sv | 9 +
 rtl/field_scan_gen_if.sv | 28 ++
 rtl/field_scan_gen.sv | 69 ++++++
 tb/tb_field_scan_gen.sv | 126 ++++++++++++
 4 files changed

// File: rtl/field_scan_gen_pkg.sv
// field_scan_gen_pkg: shared state encoding and width helper for the field scanner
package field_scan_gen_pkg;
  typedef logic [0:0] scan_state_t;
  localparam scan_state_t IDLE = 1'b0;
  localparam scan_state_t SCAN = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/field_scan_gen_if.sv
// field_scan_gen_if: beat bus (i_go/i_abort/i_continuous/i_ready in, o_valid/o_x/o_y/o_lane_mask/o_first/o_last/o_done out)
interface field_scan_gen_if import field_scan_gen_pkg::*; #(
  parameter int FIELD_W = 5,
  parameter int FIELD_H = 3,
  parameter int LANES   = 1
) ();
  localparam int XW = clog2_min1(FIELD_W);
  localparam int YW = clog2_min1(FIELD_H);
  logic             i_go;
  logic             i_abort;
  logic             i_continuous;
  logic             i_ready;
  logic             o_valid;
  logic [XW-1:0]    o_x;
  logic [YW-1:0]    o_y;
  logic [LANES-1:0] o_lane_mask;
  logic             o_first;
  logic             o_last;
  logic             o_done;
  modport master (
    input  i_go, i_abort, i_continuous, i_ready,
    output o_valid, o_x, o_y, o_lane_mask, o_first, o_last, o_done
  );
  modport slave (
    output i_go, i_abort, i_continuous, i_ready,
    input  o_valid, o_x, o_y, o_lane_mask, o_first, o_last, o_done
  );
endinterface

// File: rtl/field_scan_gen.sv
// field_scan_gen: row-major FIELD_W x FIELD_H scanner emitting LANES cells per beat; ports clk, rst, bus (master)
module field_scan_gen import field_scan_gen_pkg::*; #(
  parameter int FIELD_W = 5,
  parameter int FIELD_H = 3,
  parameter int LANES   = 1
) (
  input  logic clk,
  input  logic rst,
  field_scan_gen_if.master bus
);
  localparam int XW      = clog2_min1(FIELD_W);
  localparam int YW      = clog2_min1(FIELD_H);
  localparam int BEATS_X = (FIELD_W + LANES - 1) / LANES;
  localparam int LAST_X  = (BEATS_X - 1) * LANES;
  scan_state_t      state;
  logic [XW:0]      x_sum;
  logic             row_end, y_end, accept, is_last, load, stop;
  logic [XW-1:0]    nx, lx;
  logic [YW-1:0]    ny, ly;
  logic [LANES-1:0] lmask;
  // the extra bit keeps x+LANES from wrapping when FIELD_W is a power of two
  assign x_sum   = {1'b0, bus.o_x} + (XW+1)'(LANES);
  assign row_end = x_sum >= (XW+1)'(FIELD_W);
  assign y_end   = bus.o_y == YW'(FIELD_H - 1);
  assign nx      = row_end ? '0 : x_sum[XW-1:0];
  assign ny      = row_end ? (y_end ? '0 : bus.o_y + 1'b1) : bus.o_y;
  assign accept  = bus.o_valid & bus.i_ready;
  assign is_last = row_end & y_end;
  assign lx      = (state == IDLE) ? '0 : nx;
  assign ly      = (state == IDLE) ? '0 : ny;
  // the wrap after the last beat already lands on (0,0), so continuous mode reuses the normal advance
  assign load    = (state == IDLE) ? bus.i_go & ~bus.i_abort : accept & ~bus.i_abort & ~(is_last & ~bus.i_continuous);
  assign stop    = (state == SCAN) & (bus.i_abort | (accept & is_last & ~bus.i_continuous));
  always_comb begin
    lmask = '0;
    for (int l = 0; l < LANES; l++) lmask[l] = (int'(lx) + l) < FIELD_W;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.o_valid     <= 1'b0;
      bus.o_x         <= '0;
      bus.o_y         <= '0;
      bus.o_lane_mask <= '0;
      bus.o_first     <= 1'b0;
      bus.o_last      <= 1'b0;
      bus.o_done      <= 1'b0;
    end else begin
      bus.o_done <= (state == SCAN) & ~bus.i_abort & accept & is_last;
      if (stop) begin
        state           <= IDLE;
        bus.o_valid     <= 1'b0;
        bus.o_x         <= '0;
        bus.o_y         <= '0;
        bus.o_lane_mask <= '0;
        bus.o_first     <= 1'b0;
        bus.o_last      <= 1'b0;
      end else if (load) begin
        state           <= SCAN;
        bus.o_valid     <= 1'b1;
        bus.o_x         <= lx;
        bus.o_y         <= ly;
        bus.o_lane_mask <= lmask;
        bus.o_first     <= (lx == '0) & (ly == '0);
        bus.o_last      <= (lx == XW'(LAST_X)) & (ly == YW'(FIELD_H - 1));
      end
    end
  end
endmodule

// File: tb/tb_field_scan_gen.sv
// tb_field_scan_gen: three scanner geometries driven in lockstep against a beat-index reference model
module tb_field_scan_gen;
  logic clk = 1'b0;
  logic rst = 1'b1, go = 1'b0, abort = 1'b0, cont = 1'b0, ready = 1'b1;
  always #5 clk = ~clk;
  field_scan_gen_if #(.FIELD_W(5), .FIELD_H(3), .LANES(1)) ia ();
  field_scan_gen_if #(.FIELD_W(5), .FIELD_H(3), .LANES(2)) ib ();
  field_scan_gen_if #(.FIELD_W(1), .FIELD_H(1), .LANES(1)) ic ();
  field_scan_gen #(.FIELD_W(5), .FIELD_H(3), .LANES(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  field_scan_gen #(.FIELD_W(5), .FIELD_H(3), .LANES(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  field_scan_gen #(.FIELD_W(1), .FIELD_H(1), .LANES(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));
  assign ia.i_go = go;  assign ia.i_abort = abort;  assign ia.i_continuous = cont;  assign ia.i_ready = ready;
  assign ib.i_go = go;  assign ib.i_abort = abort;  assign ib.i_continuous = cont;  assign ib.i_ready = ready;
  assign ic.i_go = go;  assign ic.i_abort = abort;  assign ic.i_continuous = cont;  assign ic.i_ready = ready;
  logic [7:0] ov[3], ox[3], oy[3], om[3], of[3], ol[3], od[3];
  assign ov[0] = 8'(ia.o_valid); assign ox[0] = 8'(ia.o_x); assign oy[0] = 8'(ia.o_y); assign om[0] = 8'(ia.o_lane_mask);
  assign of[0] = 8'(ia.o_first); assign ol[0] = 8'(ia.o_last); assign od[0] = 8'(ia.o_done);
  assign ov[1] = 8'(ib.o_valid); assign ox[1] = 8'(ib.o_x); assign oy[1] = 8'(ib.o_y); assign om[1] = 8'(ib.o_lane_mask);
  assign of[1] = 8'(ib.o_first); assign ol[1] = 8'(ib.o_last); assign od[1] = 8'(ib.o_done);
  assign ov[2] = 8'(ic.o_valid); assign ox[2] = 8'(ic.o_x); assign oy[2] = 8'(ic.o_y); assign om[2] = 8'(ic.o_lane_mask);
  assign of[2] = 8'(ic.o_first); assign ol[2] = 8'(ic.o_last); assign od[2] = 8'(ic.o_done);
  int mw[3] = '{5, 5, 1};
  int mh[3] = '{3, 3, 1};
  int ml[3] = '{1, 2, 1};
  bit busy[3];
  bit edone[3];
  int idx[3];
  int vcnt[3];
  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int beats_x(input int i);
    return (mw[i] + ml[i] - 1) / ml[i];
  endfunction
  function automatic int beats(input int i);
    return beats_x(i) * mh[i];
  endfunction
  task automatic model(input int i);
    edone[i] = 1'b0;
    if (rst) begin
      busy[i] = 1'b0; idx[i] = 0;
    end else if (!busy[i]) begin
      if (go && !abort) begin busy[i] = 1'b1; idx[i] = 0; end
    end else if (abort) begin
      busy[i] = 1'b0; idx[i] = 0;
    end else if (ready) begin
      if (idx[i] == beats(i) - 1) begin
        edone[i] = 1'b1; idx[i] = 0; busy[i] = cont;
      end else idx[i]++;
    end
  endtask
  task automatic compare(input int i);
    int ex, ey, em;
    ex = busy[i] ? (idx[i] % beats_x(i)) * ml[i] : 0;
    ey = busy[i] ? idx[i] / beats_x(i) : 0;
    em = 0;
    if (busy[i]) for (int l = 0; l < ml[i]; l++) if (ex + l < mw[i]) em |= 1 << l;
    check($sformatf("d%0d.valid", i), int'(ov[i]), int'(busy[i]));
    check($sformatf("d%0d.x", i), int'(ox[i]), ex);
    check($sformatf("d%0d.y", i), int'(oy[i]), ey);
    check($sformatf("d%0d.mask", i), int'(om[i]), em);
    check($sformatf("d%0d.first", i), int'(of[i]), int'(busy[i] && idx[i] == 0));
    check($sformatf("d%0d.last", i), int'(ol[i]), int'(busy[i] && idx[i] == beats(i) - 1));
    check($sformatf("d%0d.done", i), int'(od[i]), int'(edone[i]));
  endtask
  task automatic step();
    for (int i = 0; i < 3; i++) model(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      compare(i);
      if (ov[i] != 0) vcnt[i]++;
    end
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic pulse_go();
    go = 1'b1; step(); go = 1'b0;
  endtask
  initial begin
    run(2);
    rst = 1'b0;
    run(2);
    for (int i = 0; i < 3; i++) vcnt[i] = 0;
    pulse_go();
    run(20);
    for (int i = 0; i < 3; i++) check($sformatf("d%0d.pass_len", i), vcnt[i], beats(i));
    pulse_go();
    for (int k = 0; k < 80; k++) begin ready = 1'($urandom_range(0, 1)); step(); end
    ready = 1'b1;
    run(5);
    cont = 1'b1;
    pulse_go();
    run(44);
    cont = 1'b0;
    run(20);
    pulse_go();
    run(6);
    abort = 1'b1; step(); abort = 1'b0;
    run(2);
    pulse_go();
    run(20);
    pulse_go();
    go = 1'b1; run(4); go = 1'b0;
    run(2);
    rst = 1'b1; step(); rst = 1'b0;
    go = 1'b1; abort = 1'b1; step(); go = 1'b0; abort = 1'b0;
    run(3);
    for (int k = 0; k < 600; k++) begin
      go    = ($urandom_range(0, 99) < 10);
      abort = ($urandom_range(0, 99) < 3);
      cont  = ($urandom_range(0, 99) < 30);
      ready = ($urandom_range(0, 99) < 60);
      rst   = ($urandom_range(0, 99) < 1);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
